// File: rtl/key_expansion_pkg.sv
// rtl/key_expansion_pkg.sv - shared types and constants for the AES-128 key schedule
package key_expansion_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] XTIME_POLY = 8'h1b;

  typedef logic [127:0] round_key_t;

  // GF(2^8) multiply-by-two, used to step the round constant
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/S_box.sv
// rtl/S_box.sv - AES forward S-box, single byte, combinational lookup
module S_box (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[a];

endmodule

// File: rtl/sub_word.sv
// rtl/sub_word.sv - SubWord: four parallel S-box lookups over a 32-bit word
module sub_word (
  input  logic [31:0] word,
  output logic [31:0] sub
);

  for (genvar g = 0; g < 4; g++) begin : g_byte
    S_box u_sbox (
      .a (word[8*g +: 8]),
      .y (sub[8*g +: 8])
    );
  end

endmodule

// File: rtl/key_expansion.sv
// rtl/key_expansion.sv - AES-128 key schedule, one round key per cycle over a valid/ready port
module key_expansion
  import key_expansion_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output round_key_t   round_key,
  output logic [3:0]   rk_index,
  output logic         busy,
  output logic         done
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  state_t     state;
  logic [7:0] rcon;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3, sub_w3, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = round_key[127:96];
  assign w1 = round_key[95:64];
  assign w2 = round_key[63:32];
  assign w3 = round_key[31:0];

  assign rot_w3 = {w3[23:0], w3[31:24]};

  sub_word u_sub_word (
    .word (rot_w3),
    .sub  (sub_w3)
  );

  // Next key is a single SubWord plus an XOR chain, so it fits one cycle
  assign t  = sub_w3 ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      round_key <= '0;
      rk_index  <= '0;
      rcon      <= RCON_INIT;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            round_key <= key_in;
            rk_index  <= '0;
            rcon      <= RCON_INIT;
            rk_valid  <= 1'b1;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (rk_valid && rk_ready) begin
            if (rk_index == LAST_IDX) begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= FIN;
            end else begin
              round_key <= {n0, n1, n2, n3};
              rk_index  <= rk_index + 4'd1;
              rcon      <= xtime(rcon);
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          rk_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_expansion.sv
// tb/tb_key_expansion.sv - scoreboard bench for key_expansion (10-round and 1-round instances)
module tb_key_expansion;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  localparam logic [127:0] KA [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] KZ1 = 128'h62636363626363636263636362636363;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         start1 = 1'b0;
  logic         rk_ready = 1'b0;
  logic [127:0] key_in = '0;

  logic         v0, b0, d0, v1, b1, d1;
  logic [127:0] k0, k1;
  logic [3:0]   i0, i1;

  int n_checks = 0;
  int n_fail = 0;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  key_expansion dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .rk_valid(v0), .rk_ready(rk_ready), .round_key(k0), .rk_index(i0),
    .busy(b0), .done(d0)
  );

  key_expansion #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .key_in(key_in),
    .rk_valid(v1), .rk_ready(rk_ready), .round_key(k1), .rk_index(i1),
    .busy(b1), .done(d1)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event/timeout expected none", name);
  endtask

  // Monitors: a transfer is predicted at the negedge before the posedge that performs it
  logic         last0 = 1'b0, stall0 = 1'b0, last1 = 1'b0, stall1 = 1'b0;
  logic [127:0] pk0, pk1;
  logic [3:0]   pi0, pi1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last0 = 1'b0;
      stall0 = 1'b0;
    end else begin
      check("done0", 128'(d0), 128'(last0));
      if (last0) check("busy_after_done0", 128'(b0), 128'd0);
      last0 = 1'b0;
      if (stall0 && v0) begin
        check("stall_key0", k0, pk0);
        check("stall_idx0", 128'(i0), 128'(pi0));
      end
      if (v0 && rk_ready) begin
        if (q0.size() == 0) fail_now("extra_key0");
        else begin
          e = q0.pop_front();
          check("idx0", 128'(i0), 128'(e.idx));
          check("key0", k0, e.key);
          if (e.idx == 4'd10) last0 = 1'b1;
        end
      end
      stall0 = v0 && !rk_ready;
      pk0 = k0;
      pi0 = i0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last1 = 1'b0;
      stall1 = 1'b0;
    end else begin
      check("done1", 128'(d1), 128'(last1));
      last1 = 1'b0;
      if (stall1 && v1) begin
        check("stall_key1", k1, pk1);
        check("stall_idx1", 128'(i1), 128'(pi1));
      end
      if (v1 && rk_ready) begin
        if (q1.size() == 0) fail_now("extra_key1");
        else begin
          e = q1.pop_front();
          check("idx1", 128'(i1), 128'(e.idx));
          check("key1", k1, e.key);
          if (e.idx == 4'd1) last1 = 1'b1;
        end
      end
      stall1 = v1 && !rk_ready;
      pk1 = k1;
      pi1 = i1;
    end
  end

  task automatic push_ka();
    for (int i = 0; i < 11; i++) q0.push_back('{idx: 4'(i), key: KA[i]});
  endtask

  task automatic do_start(input logic [127:0] k, input logic both);
    @(posedge clk); #1;
    key_in = k;
    start = 1'b1;
    start1 = both;
    @(posedge clk); #1;
    start = 1'b0;
    start1 = 1'b0;
    check("busy_after_start", 128'(b0), 128'd1);
    check("first_valid", 128'(v0), 128'd1);
  endtask

  task automatic wait_done(input logic random_ready, input logic poke_start);
    logic seen, poked;
    seen = 1'b0;
    poked = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(posedge clk); #1;
      if (d0) seen = 1'b1;
      start = 1'b0;
      if (poke_start && !poked && v0 && i0 == 4'd4) begin
        start = 1'b1;
        key_in = '0;
        poked = 1'b1;
      end
      if (random_ready) rk_ready = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    if (!seen) fail_now("done_timeout");
    rk_ready = 1'b1;
  endtask

  initial begin
    #2;
    check("rst_key", k0, 128'd0);
    check("rst_idx", 128'(i0), 128'd0);
    check("rst_valid", 128'(v0), 128'd0);
    check("rst_busy_done", 128'({b0, d0}), 128'd0);
    #10 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("idle_valid", 128'(v0), 128'd0);

    // Back-to-back stream on both instances
    rk_ready = 1'b1;
    push_ka();
    q1.push_back('{idx: 4'd0, key: KA[0]});
    q1.push_back('{idx: 4'd1, key: KA[1]});
    do_start(KA[0], 1'b1);
    wait_done(1'b0, 1'b0);
    @(posedge clk); #1;
    check("idle_busy", 128'(b0), 128'd0);
    check("idle_hold_key", k0, KA[10]);

    // Random back-pressure, with a start poke at index 4 that must be ignored
    push_ka();
    do_start(KA[0], 1'b0);
    wait_done(1'b1, 1'b1);
    check("q0_drained", 128'(q0.size()), 128'd0);

    // Abort at index 6 by asynchronous reset
    rk_ready = 1'b1;
    push_ka();
    do_start(KA[0], 1'b0);
    begin
      logic hit;
      hit = 1'b0;
      for (int c = 0; c < 50 && !hit; c++) begin
        @(posedge clk); #1;
        if (v0 && i0 == 4'd6) hit = 1'b1;
      end
      if (!hit) fail_now("idx6_timeout");
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_key", k0, 128'd0);
    check("abort_idx", 128'(i0), 128'd0);
    check("abort_valid_busy", 128'({v0, b0}), 128'd0);
    q0.delete();
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("post_reset_idle", 128'({v0, b0, d0}), 128'd0);

    // Zero key: two transfers, then stall on index 2 and reset away
    q0.push_back('{idx: 4'd0, key: 128'd0});
    q0.push_back('{idx: 4'd1, key: KZ1});
    do_start(128'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("stall_idx2", 128'(i0), 128'd2);
    check("q0_zero_drained", 128'(q0.size()), 128'd0);
    check("q1_drained", 128'(q1.size()), 128'd0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
